// File: rtl/mips_mc_controller.sv
// ---------------------------------------------------------------------------
// mips_mc_controller : multicycle MIPS main control FSM + ALU decoder
//   Optional bne support enabled by defining MC_BNE_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQ     = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       pcwrite;
  logic       branch;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic [1:0] aluop;
  logic       take_branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQ;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = BEQ;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Moore outputs; enables are masked by reset further down
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    case (state_q)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQ: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite_s = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MC_BNE_EN
  // bne shares the BEQ state; the flag inverts the sense of zero there
  logic is_bne;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_bne <= 1'b0;
    end else if (state_q == DECODE) begin
      is_bne <= (op == OP_BNE);
    end
  end

  assign take_branch = branch & (is_bne ? ~zero : zero);
`else
  assign take_branch = branch & zero;
`endif

  assign pcen     = ~reset & (pcwrite | take_branch);
  assign memwrite = ~reset & memwrite_s;
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_controller : scoreboard bench for the multicycle MIPS controller
//   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  mips_mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
  } exp_t;

  typedef struct {
    exp_t  v;
    string name;
  } item_t;

  item_t q[$];
  int    checks   = 0;
  int    failures = 0;
  exp_t  act;

  assign act = {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg,
                regdst, alusrca, alusrcb, pcsrc, alucontrol};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  // Expected Moore outputs for a state; pcen and alucontrol given by caller
  function automatic exp_t mk(input logic [3:0] st, input logic pc, input logic [2:0] alu);
    exp_t e;
    e = '0;
    e.st   = st;
    e.pcen = pc;
    e.aluc = alu;
    case (st)
      4'd0:  begin e.irwrite = 1'b1; e.alusrcb = 2'b01; end
      4'd1:  e.alusrcb = 2'b11;
      4'd2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      4'd3:  e.iord = 1'b1;
      4'd4:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
      4'd5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
      4'd6:  e.alusrca = 1'b1;
      4'd7:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
      4'd8:  begin e.alusrca = 1'b1; e.pcsrc = 2'b01; end
      4'd9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      4'd10: e.regwrite = 1'b1;
      4'd11: e.pcsrc = 2'b10;
      default: ;
    endcase
    return e;
  endfunction

  task automatic push(input string nm, input logic [3:0] st, input logic pc,
                      input logic [2:0] alu);
    item_t it;
    it.v    = mk(st, pc, alu);
    it.name = nm;
    q.push_back(it);
  endtask

  task automatic push_rst(input string nm);
    item_t it;
    it.v         = mk(4'd0, 1'b0, 3'b010);
    it.v.irwrite = 1'b0;
    it.name      = nm;
    q.push_back(it);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic z);
    op    = o;
    funct = f;
    zero  = z;
  endtask

  task automatic rtype(input string nm, input logic [5:0] f, input logic [2:0] alu);
    set_in(6'b000000, f, 1'b1);
    push({nm, "_fetch"}, 4'd0, 1'b1, 3'b010);
    push({nm, "_decode"}, 4'd1, 1'b0, 3'b010);
    push({nm, "_ex"}, 4'd6, 1'b0, alu);
    push({nm, "_wb"}, 4'd7, 1'b0, 3'b010);
    step(4);
  endtask

  // Monitor: compare one expected record per cycle at the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      checks++;
      if (act !== it.v) begin
        failures++;
        $display("FAIL %s actual=%b required=%b", it.name, act, it.v);
      end
    end
  end

  initial begin
    reset = 1'b0;
    set_in(6'b000000, 6'b000000, 1'b0);
    #1 reset = 1'b1;
    push_rst("reset_hold0");
    push_rst("reset_hold1");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // lw
    set_in(6'b100011, 6'b000000, 1'b1);
    push("lw_fetch", 4'd0, 1'b1, 3'b010);
    push("lw_decode", 4'd1, 1'b0, 3'b010);
    push("lw_memadr", 4'd2, 1'b0, 3'b010);
    push("lw_memrd", 4'd3, 1'b0, 3'b010);
    push("lw_memwb", 4'd4, 1'b0, 3'b010);
    step(5);

    // sw
    set_in(6'b101011, 6'b000000, 1'b1);
    push("sw_fetch", 4'd0, 1'b1, 3'b010);
    push("sw_decode", 4'd1, 1'b0, 3'b010);
    push("sw_memadr", 4'd2, 1'b0, 3'b010);
    push("sw_memwr", 4'd5, 1'b0, 3'b010);
    step(4);

    rtype("slt", 6'b101010, 3'b111);
    rtype("or", 6'b100101, 3'b001);
    rtype("sll0", 6'b000000, 3'b010);
    rtype("sub", 6'b100010, 3'b110);
    rtype("and", 6'b100100, 3'b000);
    rtype("add", 6'b100000, 3'b010);

    // addi
    set_in(6'b001000, 6'b101010, 1'b1);
    push("addi_fetch", 4'd0, 1'b1, 3'b010);
    push("addi_decode", 4'd1, 1'b0, 3'b010);
    push("addi_ex", 4'd9, 1'b0, 3'b010);
    push("addi_wb", 4'd10, 1'b0, 3'b010);
    step(4);

    // beq taken / not taken
    set_in(6'b000100, 6'b000000, 1'b1);
    push("beq1_fetch", 4'd0, 1'b1, 3'b010);
    push("beq1_decode", 4'd1, 1'b0, 3'b010);
    push("beq1_branch", 4'd8, 1'b1, 3'b110);
    step(3);
    set_in(6'b000100, 6'b000000, 1'b0);
    push("beq0_fetch", 4'd0, 1'b1, 3'b010);
    push("beq0_decode", 4'd1, 1'b0, 3'b010);
    push("beq0_branch", 4'd8, 1'b0, 3'b110);
    step(3);

    // j
    set_in(6'b000010, 6'b000000, 1'b0);
    push("j_fetch", 4'd0, 1'b1, 3'b010);
    push("j_decode", 4'd1, 1'b0, 3'b010);
    push("j_jump", 4'd11, 1'b1, 3'b010);
    step(3);

    // illegal opcode
    set_in(6'b111111, 6'b000000, 1'b1);
    push("ill_fetch", 4'd0, 1'b1, 3'b010);
    push("ill_decode", 4'd1, 1'b0, 3'b010);
    step(2);

`ifdef MC_BNE_EN
    set_in(6'b000101, 6'b000000, 1'b0);
    push("bne0_fetch", 4'd0, 1'b1, 3'b010);
    push("bne0_decode", 4'd1, 1'b0, 3'b010);
    push("bne0_branch", 4'd8, 1'b1, 3'b110);
    step(3);
    set_in(6'b000101, 6'b000000, 1'b1);
    push("bne1_fetch", 4'd0, 1'b1, 3'b010);
    push("bne1_decode", 4'd1, 1'b0, 3'b010);
    push("bne1_branch", 4'd8, 1'b0, 3'b110);
    step(3);
    // beq after bne must see the flag cleared again
    set_in(6'b000100, 6'b000000, 1'b1);
    push("beq2_fetch", 4'd0, 1'b1, 3'b010);
    push("beq2_decode", 4'd1, 1'b0, 3'b010);
    push("beq2_branch", 4'd8, 1'b1, 3'b110);
    step(3);
`else
    set_in(6'b000101, 6'b000000, 1'b0);
    push("bne_ill_fetch", 4'd0, 1'b1, 3'b010);
    push("bne_ill_decode", 4'd1, 1'b0, 3'b010);
    step(2);
`endif

    // Reset asserted asynchronously in the middle of MEMRD
    set_in(6'b100011, 6'b000000, 1'b1);
    push("lw2_fetch", 4'd0, 1'b1, 3'b010);
    push("lw2_decode", 4'd1, 1'b0, 3'b010);
    push("lw2_memadr", 4'd2, 1'b0, 3'b010);
    step(3);
    push("lw2_memrd", 4'd3, 1'b0, 3'b010);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {24'd0, state, pcen, memwrite, irwrite, regwrite}, 32'd0);
    push_rst("reset_mid0");
    push_rst("reset_mid1");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // First fetch after reset, then a full sw to confirm normal operation
    set_in(6'b101011, 6'b000000, 1'b0);
    push("post_rst_fetch", 4'd0, 1'b1, 3'b010);
    push("post_rst_decode", 4'd1, 1'b0, 3'b010);
    push("post_rst_memadr", 4'd2, 1'b0, 3'b010);
    push("post_rst_memwr", 4'd5, 1'b0, 3'b010);
    step(4);

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
